// File: rtl/pipe_mac_hs.sv
// Two-stage (a+b)*c pipeline with valid/ready handshakes on both sides.
// mode=1 accumulates products into a wrapping accumulator and flags the carry-out.
`timescale 1ns/1ps
module pipe_mac_hs #(
  parameter int unsigned W     = 8,
  parameter int unsigned ACC_W = 2*W+8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W-1:0]     a,
  input  logic [W-1:0]     b,
  input  logic [W-1:0]     c,
  input  logic             mode,
  input  logic             acc_clr,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] d,
  output logic             ovf
);

  localparam int unsigned SUM_W  = W + 1;
  localparam int unsigned PROD_W = 2*W + 1;
  localparam int unsigned ACC_XW = ACC_W + 1;

  typedef struct packed {
    logic [SUM_W-1:0] sum;
    logic [W-1:0]     c;
    logic             mode;
    logic             clr;
  } s1_t;

  logic              v1;
  logic              v2;
  s1_t               s1;
  logic [ACC_W-1:0]  acc;

  logic              adv1;
  logic              adv2;
  logic [SUM_W-1:0]  sum_c;
  logic [PROD_W-1:0] prod_c;
  logic [ACC_W-1:0]  prod_ext_c;
  logic [ACC_W-1:0]  base_c;
  logic [ACC_XW-1:0] acc_sum_c;

  // Handshake: a stage advances when it is empty or its successor advances.
  always_comb begin
    adv2     = !v2 || out_ready;
    adv1     = !v1 || adv2;
    in_ready = adv1;
  end

  // Full-precision datapath: sum is W+1 bits, product 2W+1 bits, carry kept at ACC_W.
  always_comb begin
    sum_c      = SUM_W'(a) + SUM_W'(b);
    prod_c     = PROD_W'(s1.sum) * PROD_W'(s1.c);
    prod_ext_c = ACC_W'(prod_c);
    base_c     = s1.clr ? '0 : acc;
    acc_sum_c  = ACC_XW'(base_c) + ACC_XW'(prod_ext_c);
  end

  // Stage 1: capture the operand triple together with its control bits.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      v1 <= 1'b0;
      s1 <= '0;
    end else if (adv1) begin
      v1 <= in_valid;
      if (in_valid) begin
        s1.sum  <= sum_c;
        s1.c    <= c;
        s1.mode <= mode;
        s1.clr  <= acc_clr;
      end
    end
  end

  // Stage 2: result register; accumulator updates exactly once per item here.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      v2  <= 1'b0;
      d   <= '0;
      ovf <= 1'b0;
      acc <= '0;
    end else if (adv2) begin
      v2 <= v1;
      if (v1) begin
        if (s1.mode) begin
          d   <= acc_sum_c[ACC_W-1:0];
          ovf <= acc_sum_c[ACC_W];
          acc <= acc_sum_c[ACC_W-1:0];
        end else begin
          d   <= prod_ext_c;
          ovf <= 1'b0;
          if (s1.clr) begin
            acc <= '0;
          end
        end
      end
    end
  end

  assign out_valid = v2;

endmodule

// File: tb/tb_pipe_mac_hs.sv
// Scoreboard bench for pipe_mac_hs: directed cases from the plan plus random stress
// against an arithmetic reference model evaluated at input-transfer time.
`timescale 1ns/1ps
module tb_pipe_mac_hs;

  localparam int unsigned W     = 8;
  localparam int unsigned ACC_W = 17;

  typedef struct {
    longint d;
    bit     ovf;
  } exp_t;

  logic             clk;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [W-1:0]     a;
  logic [W-1:0]     b;
  logic [W-1:0]     c;
  logic             mode;
  logic             acc_clr;
  logic             out_valid;
  logic             out_ready;
  logic [ACC_W-1:0] d;
  logic             ovf;

  pipe_mac_hs #(.W(W), .ACC_W(ACC_W)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .c(c), .mode(mode), .acc_clr(acc_clr),
    .out_valid(out_valid), .out_ready(out_ready),
    .d(d), .ovf(ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  exp_t   exp_q[$];
  longint acc_m;
  int     n_cmp, n_bad;
  int     in_cnt, out_cnt, dropped;
  longint last_d;
  bit     last_ovf;

  function automatic void chk(string name, bit ok, longint act, longint req);
    n_cmp++;
    if (!ok) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
    end
  endfunction

  // Reference model: (a+b)*c with unbounded integers, accumulator wraps mod 2^ACC_W.
  function automatic exp_t model(longint ia, longint ib, longint ic, bit m, bit clr);
    exp_t   e;
    longint p, t, modulus;
    modulus = longint'(1) << ACC_W;
    p = (ia + ib) * ic;
    if (m) begin
      t     = (clr ? 0 : acc_m) + p;
      e.d   = t % modulus;
      e.ovf = (t >= modulus);
      acc_m = e.d;
    end else begin
      if (clr) acc_m = 0;
      e.d   = p;
      e.ovf = 1'b0;
    end
    return e;
  endfunction

  // Input monitor pushes expectations; output monitor compares head of queue.
  always @(negedge clk) begin
    if (rst) begin
      if (in_valid && in_ready) begin
        exp_q.push_back(model(longint'(a), longint'(b), longint'(c), mode, acc_clr));
        in_cnt++;
      end
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_output", 1'b0, longint'(d), -1);
        end else begin
          chk("d", longint'(d) == exp_q[0].d, longint'(d), exp_q[0].d);
          chk("ovf", ovf == exp_q[0].ovf, longint'(ovf), longint'(exp_q[0].ovf));
          if (out_ready) begin
            last_d   = longint'(d);
            last_ovf = ovf;
            void'(exp_q.pop_front());
            out_cnt++;
          end
        end
      end
    end
  end

  task automatic send(input int ia, input int ib, input int ic, input bit m, input bit clr);
    bit ok;
    int n;
    in_valid = 1'b1;
    a = W'(ia); b = W'(ib); c = W'(ic); mode = m; acc_clr = clr;
    ok = 1'b0;
    n = 0;
    while (!ok && n < 200) begin
      @(negedge clk);
      ok = in_ready;
      @(posedge clk);
      #1;
      n++;
    end
    if (!ok) chk("send_timeout", 1'b0, n, 200);
    in_valid = 1'b0;
  endtask

  task automatic wait_out(input int target, input string name);
    int n;
    n = 0;
    while (out_cnt < target && n < 50) begin
      @(posedge clk);
      n++;
    end
    #1;
    chk(name, out_cnt >= target, out_cnt, target);
  endtask

  task automatic run_one(input int ia, input int ib, input int ic, input bit m, input bit clr,
                         input longint exp_d, input bit exp_ovf, input string name);
    int target;
    target = out_cnt + 1;
    send(ia, ib, ic, m, clr);
    wait_out(target, {name, "_arrived"});
    chk({name, "_d"}, last_d == exp_d, last_d, exp_d);
    chk({name, "_ovf"}, last_ovf == exp_ovf, longint'(last_ovf), longint'(exp_ovf));
  endtask

  bit     bp_done;
  longint held_d;
  int     base_in, base_out, cyc, target;

  initial begin
    n_cmp = 0; n_bad = 0; in_cnt = 0; out_cnt = 0; dropped = 0; acc_m = 0;
    last_d = 0; last_ovf = 1'b0;
    rst = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    a = '0; b = '0; c = '0; mode = 1'b0; acc_clr = 1'b0;

    #12;
    chk("rst_out_valid", out_valid == 1'b0, longint'(out_valid), 0);
    chk("rst_d", d == '0, longint'(d), 0);
    chk("rst_in_ready", in_ready == 1'b1, longint'(in_ready), 1);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;

    // Latency and untruncated 9-bit sum.
    out_ready = 1'b1;
    send(200, 100, 255, 1'b0, 1'b0);
    @(negedge clk);
    chk("lat_cycle1_valid", out_valid == 1'b0, longint'(out_valid), 0);
    @(negedge clk);
    chk("lat_cycle2_valid", out_valid == 1'b1, longint'(out_valid), 1);
    chk("lat_d", longint'(d) == 76500, longint'(d), 76500);
    @(posedge clk); #1;
    wait_out(1, "lat_popped");

    // Accumulate sequence with clears and an interleaved product item.
    run_one(1, 2, 3, 1'b1, 1'b1,  9, 1'b0, "acc1");
    run_one(4, 4, 2, 1'b1, 1'b0, 25, 1'b0, "acc2");
    run_one(0, 5, 5, 1'b1, 1'b1, 25, 1'b0, "acc_clr_mode1");
    run_one(1, 1, 1, 1'b0, 1'b0,  2, 1'b0, "prod_interleave");
    run_one(1, 0, 1, 1'b1, 1'b0, 26, 1'b0, "acc_resume");

    // Backpressure: only two items fit while the consumer stalls.
    out_ready = 1'b0;
    base_in  = in_cnt;
    base_out = out_cnt;
    bp_done  = 1'b0;
    fork
      begin
        send(10, 20, 3, 1'b0, 1'b0);
        send(1, 1, 1, 1'b1, 1'b1);
        send(255, 255, 255, 1'b0, 1'b0);
        send(7, 8, 9, 1'b1, 1'b0);
        bp_done = 1'b1;
      end
    join_none
    repeat (5) @(posedge clk);
    @(negedge clk);
    chk("bp_accepted", in_cnt - base_in == 2, in_cnt - base_in, 2);
    chk("bp_in_ready_low", in_ready == 1'b0, longint'(in_ready), 0);
    held_d = longint'(d);
    repeat (3) @(negedge clk);
    chk("bp_d_stable", longint'(d) == held_d, longint'(d), held_d);
    chk("bp_valid_held", out_valid == 1'b1, longint'(out_valid), 1);
    @(posedge clk); #1;
    out_ready = 1'b1;
    cyc = 0;
    while (!bp_done && cyc < 50) begin
      @(posedge clk);
      cyc++;
    end
    chk("bp_sender_done", bp_done, longint'(bp_done), 1);
    wait_out(base_out + 4, "bp_all_out");
    repeat (3) @(posedge clk);
    #1;
    chk("bp_no_dup", out_cnt - base_out == 4, out_cnt - base_out, 4);

    // Overflow at ACC_W=17.
    run_one(200, 100, 255, 1'b1, 1'b1, 76500, 1'b0, "ovf_first");
    run_one(200, 100, 255, 1'b1, 1'b0, 21928, 1'b1, "ovf_wrap");
    run_one(0, 1, 1, 1'b1, 1'b0, 21929, 1'b0, "ovf_after");

    // Asynchronous reset with both stages full.
    out_ready = 1'b0;
    send(3, 3, 3, 1'b1, 1'b0);
    send(4, 4, 4, 1'b1, 1'b0);
    #3;
    rst = 1'b0;
    dropped += exp_q.size();
    exp_q.delete();
    acc_m = 0;
    #1;
    chk("mid_rst_out_valid", out_valid == 1'b0, longint'(out_valid), 0);
    chk("mid_rst_d", d == '0, longint'(d), 0);
    chk("mid_rst_in_ready", in_ready == 1'b1, longint'(in_ready), 1);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b1;
    run_one(1, 1, 1, 1'b1, 1'b0, 2, 1'b0, "post_rst_acc");

    // Random stress with random valid/ready.
    target = in_cnt + 10000;
    cyc = 0;
    while (in_cnt < target && cyc < 60000) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      a         = W'($urandom);
      b         = W'($urandom);
      c         = W'($urandom);
      mode      = 1'($urandom);
      acc_clr   = ($urandom_range(0, 7) == 0);
      out_ready = ($urandom_range(0, 3) != 0);
      @(posedge clk);
      #1;
      cyc++;
    end
    in_valid = 1'b0;
    chk("stress_items_sent", in_cnt >= target, in_cnt, target);
    out_ready = 1'b1;
    cyc = 0;
    while (exp_q.size() != 0 && cyc < 50) begin
      @(posedge clk);
      cyc++;
    end
    repeat (2) @(posedge clk);
    #1;
    chk("stress_drained", exp_q.size() == 0, exp_q.size(), 0);
    chk("stress_item_count", out_cnt + dropped == in_cnt, out_cnt + dropped, in_cnt);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
